apb_mem_responder: RTL and testbench

- APB responder (slave) bridging APB transfers from apb_converter to the native single-port memory handshake (cs/we/re/addr/data_in, ready/data_out).
- Sits between the APB bus and the mem block.
- Inserts wait states via pready until the memory answers.
- Flags out-of-range or timed-out accesses with pslverr.

---
 rtl/apb_mem_pkg.sv | 19 +
 rtl/apb_mem_timeout.sv | 37 +++
 rtl/apb_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_apb_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and defaults for the APB-to-memory responder and its helpers.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_REQ = 2'd1,
    RESP    = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_DEF    = 32'd8;
  localparam int unsigned DATA_W_DEF    = 32'd8;
  localparam int unsigned MEM_DEPTH_DEF = 32'd256;
  localparam int unsigned TIMEOUT_DEF   = 32'd16;

  function automatic logic addr_in_range(input logic [31:0] a, input int unsigned depth);
    return (a < depth);
  endfunction

endpackage

// File: rtl/apb_mem_timeout.sv
// Clearable saturating down-counter; expired is high once the loaded budget is used up.
module apb_mem_timeout
  import apb_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 32'd1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 32'd1);

  logic [CNT_W-1:0] count_r;

  // Remaining-cycle counter: clear wins over load, load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= LOAD_VAL;
    end else if (en && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/apb_mem_responder.sv
// APB responder bridging APB transfers onto a single-port memory handshake,
// holding pready low until the memory answers and flagging bad accesses with pslverr.
module apb_mem_responder
  import apb_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic              psel,
  input  logic              penable,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              cs,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              ready
);

  state_e state_r, state_nxt_s;

  logic [DATA_W-1:0] prdata_r,  prdata_nxt_s;
  logic              pready_r,  pready_nxt_s;
  logic              pslverr_r, pslverr_nxt_s;
  logic              cs_r,      cs_nxt_s;
  logic              we_r,      we_nxt_s;
  logic              re_r,      re_nxt_s;
  logic [ADDR_W-1:0] addr_r,    addr_nxt_s;
  logic [DATA_W-1:0] din_r,     din_nxt_s;
  logic              wr_r,      wr_nxt_s;

  logic tmr_clr_s, tmr_load_s, tmr_en_s, tmr_expired_s;
  logic in_range_s;

  assign in_range_s = addr_in_range(32'(paddr), MEM_DEPTH);

  apb_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (resetn),
    .clr     (tmr_clr_s),
    .load    (tmr_load_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt_s   = state_r;
    prdata_nxt_s  = prdata_r;
    pready_nxt_s  = 1'b0;
    pslverr_nxt_s = 1'b0;
    cs_nxt_s      = cs_r;
    we_nxt_s      = we_r;
    re_nxt_s      = re_r;
    addr_nxt_s    = addr_r;
    din_nxt_s     = din_r;
    wr_nxt_s      = wr_r;
    tmr_clr_s     = 1'b0;
    tmr_load_s    = 1'b0;
    tmr_en_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (psel && !penable) begin
          wr_nxt_s = pwrite;
          if (in_range_s) begin
            state_nxt_s = MEM_REQ;
            cs_nxt_s    = 1'b1;
            we_nxt_s    = pwrite;
            re_nxt_s    = ~pwrite;
            addr_nxt_s  = paddr;
            din_nxt_s   = pwdata;
            tmr_load_s  = 1'b1;
          end else begin
            // Out-of-range: answer immediately, leave the memory port alone.
            state_nxt_s   = RESP;
            pready_nxt_s  = 1'b1;
            pslverr_nxt_s = 1'b1;
            prdata_nxt_s  = {DATA_W{1'b0}};
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end

      MEM_REQ: begin
        if (!psel) begin
          state_nxt_s = IDLE;
          cs_nxt_s    = 1'b0;
          we_nxt_s    = 1'b0;
          re_nxt_s    = 1'b0;
          tmr_clr_s   = 1'b1;
        end else if (ready) begin
          // A ready in the expiry cycle still counts as a normal completion.
          state_nxt_s  = RESP;
          cs_nxt_s     = 1'b0;
          we_nxt_s     = 1'b0;
          re_nxt_s     = 1'b0;
          pready_nxt_s = 1'b1;
          if (!wr_r) begin
            prdata_nxt_s = data_out;
          end else begin
            prdata_nxt_s = prdata_r;
          end
        end else if (tmr_expired_s) begin
          state_nxt_s   = RESP;
          cs_nxt_s      = 1'b0;
          we_nxt_s      = 1'b0;
          re_nxt_s      = 1'b0;
          pready_nxt_s  = 1'b1;
          pslverr_nxt_s = 1'b1;
          prdata_nxt_s  = {DATA_W{1'b0}};
        end else begin
          tmr_en_s = 1'b1;
        end
      end

      RESP: begin
        state_nxt_s = IDLE;
        tmr_clr_s   = 1'b1;
      end

      default: begin
        state_nxt_s = IDLE;
        cs_nxt_s    = 1'b0;
        we_nxt_s    = 1'b0;
        re_nxt_s    = 1'b0;
        tmr_clr_s   = 1'b1;
      end
    endcase
  end

  // Output and transfer-context registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prdata_r  <= {DATA_W{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      cs_r      <= 1'b0;
      we_r      <= 1'b0;
      re_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      din_r     <= {DATA_W{1'b0}};
      wr_r      <= 1'b0;
    end else begin
      prdata_r  <= prdata_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      cs_r      <= cs_nxt_s;
      we_r      <= we_nxt_s;
      re_r      <= re_nxt_s;
      addr_r    <= addr_nxt_s;
      din_r     <= din_nxt_s;
      wr_r      <= wr_nxt_s;
    end
  end

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;
  assign cs      = cs_r;
  assign we      = we_r;
  assign re      = re_r;
  assign addr    = addr_r;
  assign data_in = din_r;

endmodule

// File: tb/tb_apb_mem_responder.sv
// Bench for apb_mem_responder: transfer-level model with per-cycle output checks,
// plus a second instance with a 128-entry window for the out-of-range path.
module tb_apb_mem_responder;

  localparam int TO      = 16;
  localparam int DEPTH_A = 256;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] paddr, pwdata, prdata, addr, data_in, data_out;
  logic       pwrite, psel, penable, pready, pslverr, cs, we, re, ready;

  apb_mem_responder #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(DEPTH_A), .TIMEOUT(TO)) u_dut (
    .clk(clk), .resetn(resetn), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cs(cs), .we(we), .re(re), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ready(ready)
  );

  logic [7:0] paddr_b, pwdata_b, prdata_b, addr_b, data_in_b;
  logic       pwrite_b, psel_b, penable_b, pready_b, pslverr_b, cs_b, we_b, re_b;

  apb_mem_responder #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .resetn(resetn), .paddr(paddr_b), .pwrite(pwrite_b), .psel(psel_b),
    .penable(penable_b), .pwdata(pwdata_b), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .cs(cs_b), .we(we_b), .re(re_b), .addr(addr_b),
    .data_in(data_in_b), .data_out(8'h77), .ready(cs_b)
  );

  // Memory: answers in the mem_lat-th cycle of cs (mem_lat=0 never answers).
  logic [7:0] mem_arr [256];
  int         mem_lat = 0;
  int         lat_cnt = 0;
  logic       stray_ready = 1'b0;
  assign ready    = stray_ready | (cs && mem_lat != 0 && lat_cnt == mem_lat - 1);
  assign data_out = ready ? mem_arr[addr] : 8'h5A;
  always @(posedge clk) begin
    if (cs) lat_cnt <= lat_cnt + 1;
    else    lat_cnt <= 0;
    if (cs && we && ready) mem_arr[addr] <= data_in;
  end

  // Monitors: cycle number, cs-high cycle counts, cycle of the latest pready.
  int cyc = 0, cs_cnt = 0, csb_cnt = 0, pr_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cs)   cs_cnt  <= cs_cnt + 1;
    if (cs_b) csb_cnt <= csb_cnt + 1;
  end
  always @(negedge clk) if (pready) pr_cyc <= cyc;

  int checks = 0, errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model state: expected outputs for the current cycle and expected memory contents.
  logic       e_cs = 1'b0, e_we = 1'b0, e_re = 1'b0, e_pready = 1'b0, e_pslverr = 1'b0;
  logic [7:0] e_addr = 8'h00, e_din = 8'h00, e_prdata = 8'h00;
  logic [7:0] model_mem [256];
  logic       chk_en = 1'b0;
  int         last_len, last_cs;

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cs", cs, e_cs);
      cmp("we", we, e_we);
      cmp("re", re, e_re);
      cmp("addr", addr, e_addr);
      cmp("data_in", data_in, e_din);
      cmp("pready", pready, e_pready);
      cmp("pslverr", pslverr, e_pslverr);
      cmp("prdata", prdata, e_prdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; lat = memory latency in cycles, 0 = never answers.
  task automatic xfer(input logic [7:0] a, input logic w, input logic [7:0] wd, input int lat);
    int csn, st, cs0;
    logic inr, err;
    inr = (int'(a) < DEPTH_A);
    err = !inr || lat == 0 || lat > TO;
    csn = !inr ? 0 : ((lat == 0 || lat > TO) ? TO : lat);
    mem_lat = lat;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd;
    e_cs = 1'b0; e_we = 1'b0; e_re = 1'b0; e_pready = 1'b0; e_pslverr = 1'b0;
    st = cyc; cs0 = cs_cnt;
    step();
    penable = 1'b1; paddr = ~a; pwdata = ~wd;
    for (int k = 1; k <= csn; k++) begin
      e_cs = 1'b1; e_we = w; e_re = !w; e_addr = a; e_din = wd;
      step();
    end
    e_cs = 1'b0; e_we = 1'b0; e_re = 1'b0; e_pready = 1'b1; e_pslverr = err;
    e_prdata = err ? 8'h00 : (w ? e_prdata : model_mem[a]);
    if (w && !err) model_mem[a] = wd;
    step();
    e_pready = 1'b0; e_pslverr = 1'b0;
    last_len = pr_cyc - st + 1;
    last_cs  = cs_cnt - cs0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int csb0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    psel_b = 1'b0; penable_b = 1'b0; pwrite_b = 1'b0; paddr_b = 8'h00; pwdata_b = 8'h00;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    #2 resetn = 1'b0;
    chk_en = 1'b1;
    step(); step();
    resetn = 1'b1;
    step();
    cmp("rst_prdata", prdata, 8'h00);
    cmp("rst_cs", cs, 1'b0);

    // Write 0xAC to 0xCC then read it back, memory answering in 1 cycle.
    xfer(8'hCC, 1'b1, 8'hAC, 1);
    cmp("wr_cs_len", last_cs, 1);
    cmp("wr_len", last_len, 3);
    xfer(8'hCC, 1'b0, 8'h00, 1);
    cmp("rd_prdata", prdata, 8'hAC);
    cmp("rd_len", last_len, 3);

    // Every address: write i, read i, back to back with varied latency.
    for (int i = 0; i < 256; i++) begin
      xfer(8'(i), 1'b1, 8'(i), 1 + (i % 3));
      xfer(8'(i), 1'b0, 8'h00, 1 + (i % 2));
    end
    cmp("loop_last", prdata, 8'hFF);
    idle(2);

    // Memory never answers: exactly TIMEOUT cycles of cs, then an error.
    xfer(8'h10, 1'b0, 8'h00, 0);
    cmp("to_cs_len", last_cs, 16);
    cmp("to_len", last_len, 18);
    cmp("to_prdata", prdata, 8'h00);
    // Ready in the very last allowed cycle wins; one later is a timeout.
    xfer(8'h30, 1'b0, 8'h00, 16);
    cmp("edge_prdata", prdata, 8'h30);
    cmp("edge_cs_len", last_cs, 16);
    xfer(8'h20, 1'b1, 8'hEE, 17);
    xfer(8'h20, 1'b0, 8'h00, 1);
    cmp("to_nowrite", prdata, 8'h20);

    // Abort: psel drops in the third MEM_REQ cycle, then stray ready in idle.
    mem_lat = 0;
    psel = 1'b1; penable = 1'b0; paddr = 8'h55; pwrite = 1'b0; pwdata = 8'h00;
    step();
    penable = 1'b1;
    e_cs = 1'b1; e_we = 1'b0; e_re = 1'b1; e_addr = 8'h55; e_din = 8'h00;
    step(); step();
    psel = 1'b0; penable = 1'b0;
    step();
    e_cs = 1'b0; e_re = 1'b0;
    stray_ready = 1'b1;
    step(); step();
    stray_ready = 1'b0;
    step();
    // Counter must start fresh after the abort.
    xfer(8'h55, 1'b0, 8'h00, 0);
    cmp("abort_to_cs_len", last_cs, 16);

    // Reset mid-transfer.
    mem_lat = 0;
    psel = 1'b1; penable = 1'b0; paddr = 8'h44; pwrite = 1'b1; pwdata = 8'h99;
    step();
    penable = 1'b1;
    e_cs = 1'b1; e_we = 1'b1; e_re = 1'b0; e_addr = 8'h44; e_din = 8'h99;
    step(); step();
    #2 resetn = 1'b0;
    psel = 1'b0; penable = 1'b0;
    e_cs = 1'b0; e_we = 1'b0; e_re = 1'b0; e_addr = 8'h00; e_din = 8'h00;
    e_pready = 1'b0; e_pslverr = 1'b0; e_prdata = 8'h00;
    #1;
    cmp("async_rst_cs", cs, 1'b0);
    cmp("async_rst_we", we, 1'b0);
    step(); step();
    resetn = 1'b1;
    step();
    xfer(8'h44, 1'b0, 8'h00, 2);
    cmp("post_rst_prdata", prdata, 8'h44);
    xfer(8'h44, 1'b1, 8'h3C, 1);
    xfer(8'h44, 1'b0, 8'h00, 1);
    cmp("post_rst_wr", prdata, 8'h3C);
    idle(2);

    // Second instance, MEM_DEPTH=128: 0x80 is rejected, 0x7F is served.
    csb0 = csb_cnt;
    psel_b = 1'b1; penable_b = 1'b0; paddr_b = 8'h80; pwrite_b = 1'b0; pwdata_b = 8'h11;
    step();
    penable_b = 1'b1;
    cmp("oor_pready", pready_b, 1'b1);
    cmp("oor_pslverr", pslverr_b, 1'b1);
    cmp("oor_cs", cs_b, 1'b0);
    cmp("oor_prdata", prdata_b, 8'h00);
    step();
    cmp("oor_done", pready_b, 1'b0);
    penable_b = 1'b0; paddr_b = 8'h7F; pwdata_b = 8'h22;
    step();
    penable_b = 1'b1;
    cmp("b_cs", cs_b, 1'b1);
    cmp("b_re", re_b, 1'b1);
    cmp("b_we", we_b, 1'b0);
    cmp("b_addr", addr_b, 8'h7F);
    cmp("b_din", data_in_b, 8'h22);
    step();
    cmp("b_pready", pready_b, 1'b1);
    cmp("b_pslverr", pslverr_b, 1'b0);
    cmp("b_prdata", prdata_b, 8'h77);
    step();
    psel_b = 1'b0; penable_b = 1'b0;
    cmp("b_cs_count", csb_cnt - csb0, 1);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
